// File: rtl/nic_channel_ctrl.sv
// NIC channel controller: one-entry output and input flit buffers between the
// processor memory stage and the ring router, with status flags and VC gating.
module nic_channel_ctrl #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned VC_BIT     = 63
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  nicEn,
   input  logic                  nicEnWr,
   input  logic [1:0]            adder_nic,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  net_ro,
   input  logic                  net_polarity,
   output logic                  net_so,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di
);

   localparam logic [1:0] SEL_IN_BUF  = 2'b00;
   localparam logic [1:0] SEL_IN_STS  = 2'b01;
   localparam logic [1:0] SEL_OUT_BUF = 2'b10;
   localparam logic [1:0] SEL_OUT_STS = 2'b11;

   logic [DATA_WIDTH-1:0] out_buf;
   logic [DATA_WIDTH-1:0] in_buf;
   logic                  out_full;
   logic                  in_full;
   logic                  proc_wr_out;
   logic                  proc_rd_in;
   logic                  send;

   assign proc_wr_out = nicEn & nicEnWr & (adder_nic == SEL_OUT_BUF);
   assign proc_rd_in  = nicEn & ~nicEnWr & (adder_nic == SEL_IN_BUF);
   // Router only takes a flit whose VC differs from its current polarity
   assign send        = out_full & net_ro & (out_buf[VC_BIT] != net_polarity);
   assign net_ri      = ~in_full;

   // Output side: a send drains the buffer; a write is only accepted when empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_buf  <= '0;
         out_full <= 1'b0;
         net_so   <= 1'b0;
         net_do   <= '0;
      end else if (send) begin
         net_so   <= 1'b1;
         net_do   <= out_buf;
         out_full <= 1'b0;
      end else begin
         net_so <= 1'b0;
         if (proc_wr_out && !out_full) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
         end
      end
   end

   // Input side: fill and read cannot coincide since net_ri is low while full
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_buf  <= '0;
         in_full <= 1'b0;
      end else if (net_si && !in_full) begin
         in_buf  <= net_di;
         in_full <= 1'b1;
      end else if (proc_rd_in && in_full) begin
         in_full <= 1'b0;
      end
   end

   // Same-cycle load data for the MEM/WB register
   always_comb begin
      d_out = '0;
      if (nicEn && !nicEnWr) begin
         case (adder_nic)
            SEL_IN_BUF:  d_out = in_buf;
            SEL_IN_STS:  d_out = DATA_WIDTH'(in_full);
            SEL_OUT_BUF: d_out = '0;
            SEL_OUT_STS: d_out = DATA_WIDTH'(out_full);
            default:     d_out = '0;
         endcase
      end
   end

endmodule
